// File: rtl/instruction_fetch.sv
// Fetch stage: holds the fetch PC, runs a single-outstanding req/ack read to
// instruction memory, buffers {pc, instr} pairs in a small prefetch FIFO and
// presents the head entry to decode. Handles stall, redirect and halt.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ill_instr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD,
        S_HALT_WAIT,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic [31:0]      r_hold_addr;
    logic [31:0]      w_hold_addr_nxt;

    logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]      r_fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_halted;
    logic             w_valid;
    logic             w_pending;
    logic             w_illegal;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [31:0]      w_redirect_target;
    logic [31:0]      w_pc;

    assign w_halted          = (r_state == S_HALT_WAIT) || (r_state == S_HALT);
    assign w_valid           = (r_count != '0) && !w_halted;
    assign w_pending         = imem_req && !imem_ack;
    assign w_illegal         = ill_instr && w_valid && !redirect;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Memory request side: derived from registered state only. While an
    // abandoned request drains, the address is held on the original target.
    always_comb begin
        imem_req = 1'b0;
        case (r_state)
            S_FETCH:                imem_req = (r_count < CNT_W'(FIFO_DEPTH));
            S_DISCARD, S_HALT_WAIT: imem_req = 1'b1;
            default:                imem_req = 1'b0;
        endcase
        imem_addr = ((r_state == S_DISCARD) || (r_state == S_HALT_WAIT)) ? r_hold_addr : r_fetch_pc;
    end

    // Decode-side view of the FIFO head.
    always_comb begin
        w_pc        = w_valid ? r_fifo_pc[r_rd_ptr] : RESET_PC;
        instruction = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
        pc          = w_pc;
        pc_plus4    = w_pc + 32'd4;
        instr_valid = w_valid;
        halted      = w_halted;
    end

    // Next state, next fetch PC and FIFO push/pop/flush decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_hold_addr_nxt = r_hold_addr;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (redirect) begin
                    w_fetch_pc_nxt = w_redirect_target;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_target;
                    if (w_pending) begin
                        w_state_nxt     = S_DISCARD;
                        w_hold_addr_nxt = r_fetch_pc;
                    end
                end else if (w_illegal) begin
                    w_flush = 1'b1;
                    if (w_pending) begin
                        w_state_nxt     = S_HALT_WAIT;
                        w_hold_addr_nxt = r_fetch_pc;
                    end else begin
                        w_state_nxt = S_HALT;
                    end
                end else begin
                    w_pop = w_valid && !stall;
                    if (imem_req && imem_ack) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redirect_target;
                end
                if (imem_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_hold_addr <= w_hold_addr_nxt;
        end
    end

    // FIFO pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful under r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: randomized stalls, redirects, illegal flags
// and memory latency, checked against a queue-based transaction model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ill_instr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_instruction;
    logic [31:0] wr_pc;
    logic [31:0] wr_pc_plus4;
    logic        wr_valid;
    logic        wr_halted;

    instruction_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ill_instr  (ill_instr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .halted     (halted)
    );

    // Second instance starting at the top of the address space, zero-wait memory.
    instruction_fetch #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (NOP),
        .FIFO_DEPTH(2)
    ) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (1'b0),
        .redirect   (1'b0),
        .redirect_pc(32'h0),
        .ill_instr  (1'b0),
        .imem_req   (wr_req),
        .imem_addr  (wr_addr),
        .imem_ack   (wr_req),
        .imem_rdata (wr_addr),
        .instruction(wr_instruction),
        .pc         (wr_pc),
        .pc_plus4   (wr_pc_plus4),
        .instr_valid(wr_valid),
        .halted     (wr_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    // Reference model: fetched-but-unconsumed words, next fetch address,
    // and whether an in-flight read must be thrown away.
    entry_t      q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_drop_addr;
    bit          m_started;
    bit          m_halted;
    bit          m_drop;
    bit          mem_busy;
    int          mem_cnt;

    int n_checks;
    int n_errors;
    bit track_pc8;
    bit saw_pc8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic bit m_valid();
        return (q.size() != 0) && !m_halted;
    endfunction

    function automatic bit m_req();
        if (!m_started) return 1'b0;
        if (m_halted)   return m_drop;
        if (m_drop)     return 1'b1;
        return q.size() < DEPTH;
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drop ? m_drop_addr : m_fetch_pc;
    endfunction

    function automatic logic [31:0] m_head_pc();
        return m_valid() ? q[0].pc : RST_PC;
    endfunction

    // One clock cycle: respond as memory, drive inputs, compare, advance model.
    task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit il,
                        input int lo, input int hi);
        bit          ack;
        bit          ev;
        bit          er;
        logic [31:0] rd;
        logic [31:0] ea;
        logic [31:0] epc;
        ev  = m_valid();
        er  = m_req();
        ea  = m_addr();
        epc = m_head_pc();
        ack = 1'b0;
        if (er) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(hi, lo);
            end
            ack = (mem_cnt == 0);
        end
        rd = ack ? mem_data(ea) : $urandom;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        ill_instr   = il;
        imem_ack    = ack;
        imem_rdata  = rd;

        chk("instr_valid", 32'(instr_valid), 32'(ev));
        chk("instruction", instruction, ev ? q[0].ins : NOP);
        chk("pc", pc, epc);
        chk("pc_plus4", pc_plus4, epc + 32'd4);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("imem_req", 32'(imem_req), 32'(er));
        if (er) chk("imem_addr", imem_addr, ea);
        if (track_pc8 && instr_valid && pc == 32'h8) saw_pc8 = 1'b1;

        if (!m_started) begin
            m_started = 1'b1;
            if (r) m_fetch_pc = rp & 32'hFFFF_FFFC;
        end else if (m_halted) begin
            if (m_drop && ack) m_drop = 1'b0;
        end else if (r) begin
            q.delete();
            if (m_drop) begin
                if (ack) m_drop = 1'b0;
            end else if (er && !ack) begin
                m_drop      = 1'b1;
                m_drop_addr = m_fetch_pc;
            end
            m_fetch_pc = rp & 32'hFFFF_FFFC;
        end else if (il && ev) begin
            m_halted = 1'b1;
            q.delete();
            if (er && !ack) begin
                m_drop      = 1'b1;
                m_drop_addr = m_fetch_pc;
            end
        end else if (m_drop) begin
            if (ack) m_drop = 1'b0;
        end else begin
            if (ev && !s) void'(q.pop_front());
            if (ack) begin
                q.push_back('{pc: m_fetch_pc, ins: rd});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        if (ack) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;

        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        q.delete();
        m_fetch_pc = RST_PC;
        m_started  = 1'b0;
        m_halted   = 1'b0;
        m_drop     = 1'b0;
        mem_busy   = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ill_instr = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run zero-stall cycles until the model's head pc equals target.
    task automatic run_to_pc(input logic [31:0] target, input int lo, input int hi);
        int n;
        n = 0;
        while (!(m_valid() && q[0].pc == target) && n < 60) begin
            step(1'b0, 1'b0, '0, 1'b0, lo, hi);
            n++;
        end
        if (n >= 60) chk("timeout_run_to_pc", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        bit s, r, il;
        logic [31:0] rp;
        n_checks = 0; n_errors = 0; track_pc8 = 1'b0; saw_pc8 = 1'b0;
        rst_n = 1'b0;

        // Zero-wait streaming and top-of-memory wrap.
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 0, 0);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("wrap_addr0", wr_addr, 32'hFFFF_FFFC);
        chk("wrap_req", 32'(wr_req), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 0, 0);
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_first_pc", pc, 32'h0);
        chk("wrap_addr1", wr_addr, 32'h0);
        chk("wrap_pc", wr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", wr_pc_plus4, 32'h0);
        chk("wrap_valid", 32'(wr_valid), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 0, 0);
        chk("t1_addr2", imem_addr, 32'h8);

        // Stall holds outputs; FIFO fills and the request drops.
        do_reset();
        run_to_pc(32'h4, 0, 0);
        repeat (4) step(1'b1, 1'b0, '0, 1'b0, 0, 0);
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_pc_held", pc, 32'h4);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0, 0, 0);

        // Redirect while a slow request is in flight.
        do_reset();
        track_pc8 = 1'b1;
        n = 0;
        while (!(m_req() && m_addr() == 32'h8 && !m_drop) && n < 60) begin
            step(1'b0, 1'b0, '0, 1'b0, 3, 3);
            n++;
        end
        if (n >= 60) chk("timeout_t3", 32'd0, 32'd1);
        step(1'b0, 1'b1, 32'h100, 1'b0, 3, 3);
        chk("t3_addr_held", imem_addr, 32'h8);
        repeat (16) step(1'b0, 1'b0, '0, 1'b0, 3, 3);
        chk("t3_no_pc8", 32'(saw_pc8), 32'd0);
        track_pc8 = 1'b0;

        // Redirect with stall and unaligned target.
        do_reset();
        repeat (5) step(1'b0, 1'b0, '0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 32'h203, 1'b0, 0, 0);
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h200);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0, 0, 0);

        // Illegal instruction halts; redirect in the same cycle suppresses it.
        do_reset();
        run_to_pc(32'h10, 2, 2);
        step(1'b0, 1'b0, '0, 1'b1, 2, 2);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 8; i++) step(i[0], i[1], 32'h40, 1'b0, 2, 2);
        chk("t5_req_off", 32'(imem_req), 32'd0);
        do_reset();
        run_to_pc(32'h10, 0, 1);
        step(1'b0, 1'b1, 32'h300, 1'b1, 0, 1);
        chk("t5b_halted", 32'(halted), 32'd0);
        repeat (6) step(1'b0, 1'b0, '0, 1'b0, 0, 1);

        // Randomized traffic over several memory latencies.
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                if ((m_halted && $urandom_range(9, 0) == 0) ||
                    (m_req() && $urandom_range(199, 0) == 0)) begin
                    do_reset();
                end
                s  = ($urandom_range(99, 0) < 30);
                r  = ($urandom_range(99, 0) < 5);
                il = ($urandom_range(99, 0) < 2);
                rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
                step(s, r, rp, il, 0, (ph == 0) ? 0 : (ph == 1) ? 1 : 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
